isn_queue: RTL and testbench

ISN_QUEUE -- requirements
Module: isn_queue

---
 rtl/isn_queue_pkg.sv | 25 ++
 rtl/isn_compact.sv | 23 ++
 rtl/isn_queue.sv | 136 +++++++++++++
 tb/tb_isn_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/isn_queue_pkg.sv
// rtl/isn_queue_pkg.sv - shared sizing defaults and pop-request encodings for the instruction queue
package isn_queue_pkg;

    localparam int ISNQ_INSN_WIDTH = 99;
    localparam int ISNQ_DEPTH      = 16;
    localparam int ISNQ_PTR_W      = $clog2(ISNQ_DEPTH);
    localparam int ISNQ_SLOTS      = 4;

    localparam logic [1:0] POP_NONE = 2'b00;
    localparam logic [1:0] POP_ONE  = 2'b01;
    localparam logic [1:0] POP_BAD  = 2'b10;
    localparam logic [1:0] POP_TWO  = 2'b11;

    // 10 is not a legal thermometer code; it is serviced as a single pop.
    function automatic logic [1:0] pop_request(input logic [1:0] pop);
        logic [1:0] n;
        case (pop)
            POP_NONE: n = 2'd0;
            POP_TWO:  n = 2'd2;
            default:  n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/isn_compact.sv
// rtl/isn_compact.sv - maps per-slot write valids to compacted write offsets and a push count
module isn_compact
    import isn_queue_pkg::*;
(
    input  logic [3:0] i_valid,
    output logic [7:0] o_offset,
    output logic [2:0] o_count
);

    logic [2:0] run_c;

    // Each slot lands after every valid slot older than itself.
    always_comb begin
        run_c    = 3'd0;
        o_offset = '0;
        for (int k = 0; k < ISNQ_SLOTS; k++) begin
            o_offset[2*k +: 2] = run_c[1:0];
            run_c              = run_c + {2'b00, i_valid[k]};
        end
        o_count = run_c;
    end

endmodule

// File: rtl/isn_queue.sv
// rtl/isn_queue.sv - 4-in/2-out decoded instruction circular queue; ISN_QUEUE_CHECK_EN builds the sticky protocol checker
module isn_queue
    import isn_queue_pkg::*;
#(
    parameter int INSN_WIDTH = ISNQ_INSN_WIDTH,
    parameter int DEPTH      = ISNQ_DEPTH
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Flush,
    input  logic [3:0]            i_valid,
    input  logic [INSN_WIDTH-1:0] i_isn1,
    input  logic [INSN_WIDTH-1:0] i_isn2,
    input  logic [INSN_WIDTH-1:0] i_isn3,
    input  logic [INSN_WIDTH-1:0] i_isn4,
    input  logic [1:0]            i_pop,
    output logic                  o_stall,
    output logic [INSN_WIDTH-1:0] o_isn_out1,
    output logic [INSN_WIDTH-1:0] o_isn_out2,
    output logic [1:0]            o_out_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [INSN_WIDTH-1:0] mem_q [DEPTH];

    logic [INSN_WIDTH-1:0] slot_data [ISNQ_SLOTS];
    logic [AW-1:0]         wr_addr [ISNQ_SLOTS];
    logic [7:0]            slot_offset;
    logic [2:0]            slot_cnt;
    logic [CW-1:0]         free_slots;
    logic                  push_en;
    logic [2:0]            push_n;
    logic [1:0]            pop_req;
    logic [1:0]            pop_n;
    logic [AW-1:0]         head_p1;

    isn_compact u_compact (
        .i_valid  (i_valid),
        .o_offset (slot_offset),
        .o_count  (slot_cnt)
    );

    assign slot_data[0] = i_isn1;
    assign slot_data[1] = i_isn2;
    assign slot_data[2] = i_isn3;
    assign slot_data[3] = i_isn4;

    // Stall needs room for a full four-wide write, whatever the aligner offers.
    assign free_slots = CW'(DEPTH) - count_q;
    assign o_stall    = (free_slots < CW'(4));
    assign push_en    = !o_stall && !i_Flush;
    assign push_n     = push_en ? slot_cnt : 3'd0;
    assign pop_req    = pop_request(i_pop);

    always_comb begin
        pop_n = pop_req;
        if (count_q < CW'(pop_req)) begin
            pop_n = count_q[1:0];
        end
        if (i_Flush) begin
            pop_n = 2'd0;
        end
    end

    always_comb begin
        for (int k = 0; k < ISNQ_SLOTS; k++) begin
            wr_addr[k] = tail_q + AW'(slot_offset[2*k +: 2]);
        end
    end

    always_comb begin
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (i_Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; occupancy alone decides validity.
    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < ISNQ_SLOTS; k++) begin
            if (push_en && i_valid[k]) begin
                mem_q[wr_addr[k]] <= slot_data[k];
            end
        end
    end

    assign head_p1     = head_q + AW'(1);
    assign o_isn_out1  = mem_q[head_q];
    assign o_isn_out2  = mem_q[head_p1];
    assign o_out_valid = {count_q >= CW'(2), count_q != '0};
    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == CW'(DEPTH));

`ifdef ISN_QUEUE_CHECK_EN
    logic err_q;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            err_q <= 1'b0;
        end else if (((|i_valid) && o_stall) || (i_pop == POP_BAD)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_isn_queue.sv
// tb/tb_isn_queue.sv - scoreboard bench for isn_queue: directed scenarios then a random push/pop/flush mix
module tb_isn_queue;

    localparam int W = 99;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         i_Reset_n;
    logic         i_Flush;
    logic [3:0]   i_valid;
    logic [W-1:0] i_isn1, i_isn2, i_isn3, i_isn4;
    logic [1:0]   i_pop;
    logic         o_stall;
    logic [W-1:0] o_isn_out1, o_isn_out2;
    logic [1:0]   o_out_valid;
    logic [4:0]   o_count;
    logic         o_empty, o_full, o_err;

    always #5 clk = ~clk;

    isn_queue #(.INSN_WIDTH(W), .DEPTH(D)) dut (
        .i_Clk       (clk),
        .i_Reset_n   (i_Reset_n),
        .i_Flush     (i_Flush),
        .i_valid     (i_valid),
        .i_isn1      (i_isn1),
        .i_isn2      (i_isn2),
        .i_isn3      (i_isn3),
        .i_isn4      (i_isn4),
        .i_pop       (i_pop),
        .o_stall     (o_stall),
        .o_isn_out1  (o_isn_out1),
        .o_isn_out2  (o_isn_out2),
        .o_out_valid (o_out_valid),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_err       (o_err)
    );

    logic [W-1:0] sb [$];
    int           total = 0;
    int           bad   = 0;
    logic         err_m = 1'b0;
    logic [W-1:0] A, B, C, Dd, X, Y, J, P, Q, R, E0, E1, E2, E3;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_isn();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic cycle(input logic [3:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, input logic [1:0] p,
                         input logic f);
        logic         stall_m;
        int           npop;
        logic [W-1:0] s [4];
        i_valid = v; i_isn1 = a; i_isn2 = b; i_isn3 = c; i_isn4 = d;
        i_pop = p; i_Flush = f;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        stall_m = ((D - sb.size()) < 4);
        chk("stall", o_stall, stall_m);
        if (sb.size() >= 1) chk("out1", o_isn_out1, sb[0]);
        if (sb.size() >= 2) chk("out2", o_isn_out2, sb[1]);
`ifdef ISN_QUEUE_CHECK_EN
        if (((v != 4'b0) && stall_m) || (p == 2'b10)) err_m = 1'b1;
`endif
        npop = (p == 2'b00) ? 0 : ((p == 2'b11) ? 2 : 1);
        if (npop > sb.size()) npop = sb.size();
        if (f) begin
            sb.delete();
        end else begin
            for (int i = 0; i < npop; i++) void'(sb.pop_front());
            if (!stall_m) begin
                for (int k = 0; k < 4; k++) if (v[k]) sb.push_back(s[k]);
            end
        end
        @(posedge clk);
        #1;
        chk("count", o_count, sb.size());
        chk("empty", o_empty, sb.size() == 0);
        chk("full", o_full, sb.size() == D);
        chk("out_valid", o_out_valid, {sb.size() >= 2, sb.size() >= 1});
        chk("err", o_err, err_m);
    endtask

    task automatic push4r(input logic [3:0] v);
        cycle(v, rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn(), 2'b00, 1'b0);
    endtask

    task automatic pop(input logic [1:0] p);
        cycle(4'b0000, '0, '0, '0, '0, p, 1'b0);
    endtask

    initial begin
        A = 99'h0AAAA_0001; B = 99'h0BBBB_0002; C = 99'h0CCCC_0003; Dd = 99'h0DDDD_0004;
        X = 99'h7_1234_5678_9ABC; Y = 99'h6_FEDC_BA98_7654; J = 99'h5_DEAD_BEEF;
        P = 99'h111; Q = 99'h222; R = 99'h333;
        E0 = 99'hE0E0; E1 = 99'hE1E1; E2 = 99'hE2E2; E3 = 99'hE3E3;
        i_Reset_n = 1'b0; i_Flush = 1'b0; i_valid = 4'b0; i_pop = 2'b0;
        i_isn1 = '0; i_isn2 = '0; i_isn3 = '0; i_isn4 = '0;
        #12;
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_err", o_err, 0);
        @(posedge clk); #1;
        i_Reset_n = 1'b1;

        cycle(4'b1111, A, B, C, Dd, 2'b00, 1'b0);
        chk("s1_out1", o_isn_out1, A);
        chk("s1_out2", o_isn_out2, B);

        cycle(4'b1010, J, X, J, Y, 2'b00, 1'b0);
        pop(2'b11);
        pop(2'b11);
        chk("s2_x", o_isn_out1, X);
        chk("s2_y", o_isn_out2, Y);
        pop(2'b11);

        for (int i = 0; i < 3; i++) push4r(4'b1111);
        push4r(4'b0001);
        chk("s3_stall", o_stall, 1);
        push4r(4'b1111);
        chk("s3_count_held", o_count, 13);
        for (int i = 0; i < 7; i++) pop(2'b11);

        cycle(4'b0001, P, J, J, J, 2'b00, 1'b0);
        cycle(4'b0011, Q, R, J, J, 2'b11, 1'b0);
        chk("s4_q", o_isn_out1, Q);
        chk("s4_r", o_isn_out2, R);
        pop(2'b10);
        chk("s4_pop10", o_isn_out1, R);
        pop(2'b01);

        push4r(4'b1111);
        i_Reset_n = 1'b0;
        #2;
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_empty", o_empty, 1);
        chk("mid_rst_out_valid", o_out_valid, 0);
        chk("mid_rst_err", o_err, 0);
        sb.delete();
        err_m = 1'b0;
        #1;
        i_Reset_n = 1'b1;

        for (int i = 0; i < 3; i++) push4r(4'b1111);
        push4r(4'b0011);
        for (int i = 0; i < 7; i++) pop(2'b11);
        cycle(4'b1111, E0, E1, E2, E3, 2'b00, 1'b0);
        chk("wrap_e0", o_isn_out1, E0);
        chk("wrap_e1", o_isn_out2, E1);
        pop(2'b11);
        chk("wrap_e2", o_isn_out1, E2);
        chk("wrap_e3", o_isn_out2, E3);

        pop(2'b11);
        for (int i = 0; i < 4; i++) push4r(4'b1111);
        chk("full_flag", o_full, 1);
        for (int i = 0; i < 5; i++) pop(2'b11);
        cycle(4'b1111, rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn(), 2'b11, 1'b1);
        chk("flush_empty", o_empty, 1);
        chk("flush_count", o_count, 0);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] pr;
            pr = 2'($urandom_range(0, 3));
            cycle(4'($urandom_range(0, 15)), rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn(),
                  pr, ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
